// File: rtl/serial_adder_n.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first,
// and presents a registered sum, carry-out and two's-complement overflow on completion.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dovf, last;

  // Returns {overflow, carry-out, digit}; the carry into the digit MSB is
  // recovered as x^y^s at that bit, so it is exact for any DIGIT.
  function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             ci);
    logic [DIGIT:0] t;
    logic           cmsb;
    t    = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    cmsb = x[DIGIT-1] ^ y[DIGIT-1] ^ t[DIGIT-1];
    return {cmsb ^ t[DIGIT], t};
  endfunction

  assign {dovf, dcout, dsum} = digit_add(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], carry);
  assign last = (cnt == LAST);

  // New digit enters at the top; after STEPS shifts the first digit sits at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_nxt = dsum;
    end else begin : g_multi
      assign res_nxt = {dsum, res_sr[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          carry  <= cin;
          cnt    <= '0;
          res_sr <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_nxt;
          carry  <= dcout;
          cnt    <= cnt + CW'(1);
          // Outputs see only the completed result.
          if (last) begin
            sum  <= res_nxt;
            cout <= dcout;
            ovf  <= dovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: five parameterisations driven from shared
// operand buses, each started individually and compared against a local adder model.
module tb_serial_adder_n;

  logic       clk, rst_n;
  logic [7:0] a_d, b_d;
  logic       cin_d;
  logic [4:0] start_v, busy_v, done_v, cout_v, ovf_v;
  logic [7:0] sum_v [5];
  logic [3:0] s2, s3, s4;
  logic [7:0] s0, s1;

  int errs   = 0;
  int checks = 0;
  int steps_of [5] = '{8, 2, 4, 2, 1};
  int width_of [5] = '{8, 8, 4, 4, 4};

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_d), .b(b_d), .cin(cin_d), .busy(busy_v[0]), .done(done_v[0]),
    .sum(s0), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_d), .b(b_d), .cin(cin_d), .busy(busy_v[1]), .done(done_v[1]),
    .sum(s1), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder_n #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d), .busy(busy_v[2]), .done(done_v[2]),
    .sum(s2), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_adder_n #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .start(start_v[3]),
    .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d), .busy(busy_v[3]), .done(done_v[3]),
    .sum(s3), .cout(cout_v[3]), .ovf(ovf_v[3]));
  serial_adder_n #(.WIDTH(4), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start_v[4]),
    .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d), .busy(busy_v[4]), .done(done_v[4]),
    .sum(s4), .cout(cout_v[4]), .ovf(ovf_v[4]));

  assign sum_v[0] = s0;
  assign sum_v[1] = s1;
  assign sum_v[2] = {4'h0, s2};
  assign sum_v[3] = {4'h0, s3};
  assign sum_v[4] = {4'h0, s4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t vt [12];

  // Reference: {ovf, cout, sum} from a plain wide add and the sign rule.
  function automatic logic [9:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci);
    logic [8:0] full;
    logic [7:0] m, s;
    logic       co, ov;
    m    = (w == 8) ? 8'hFF : 8'h0F;
    full = {1'b0, av & m} + {1'b0, bv & m} + {8'h00, ci};
    s    = full[7:0] & m;
    co   = (w == 8) ? full[8] : full[4];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation on instance sel, scrambles the inputs after acceptance,
  // and returns result, latency, busy-cycle count and a protocol error flag.
  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, output logic [7:0] s, output logic co,
                        output logic ov, output int lat, output int bc, output bit perr);
    logic [7:0] ps;
    logic       pc, po;
    perr = 1'b0;
    @(negedge clk);
    a_d = av; b_d = bv; cin_d = ci; start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    a_d = ~av; b_d = bv ^ 8'h5A; cin_d = ~ci;
    ps = sum_v[sel]; pc = cout_v[sel]; po = ovf_v[sel];
    bc = busy_v[sel] ? 1 : 0;
    lat = 0;
    while (!done_v[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[sel]) bc++;
      if (!done_v[sel] && (sum_v[sel] !== ps || cout_v[sel] !== pc || ovf_v[sel] !== po))
        perr = 1'b1;
    end
    s = sum_v[sel]; co = cout_v[sel]; ov = ovf_v[sel];
    @(posedge clk); #1;
    if (done_v[sel] || busy_v[sel]) perr = 1'b1;
  endtask

  logic [7:0] rs;
  logic       rc, ro;
  int         lat, bc;
  bit         perr;
  logic [9:0] m;

  initial begin
    vt[0]  = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[1]  = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2]  = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3]  = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5]  = '{0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vt[7]  = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[8]  = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[9]  = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[10] = '{1, 8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[11] = '{1, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; start_v = '0; a_d = '0; b_d = '0; cin_d = 1'b0;
    #1;
    chk("reset busy", {27'd0, busy_v}, 32'd0);
    chk("reset done", {27'd0, done_v}, 32'd0);
    chk("reset sum0", {24'd0, sum_v[0]}, 32'd0);
    chk("reset cout/ovf", {22'd0, cout_v, ovf_v}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].ci, rs, rc, ro, lat, bc, perr);
      chk($sformatf("vec%0d sum", i), {24'd0, rs}, {24'd0, vt[i].s});
      chk($sformatf("vec%0d cout", i), {31'd0, rc}, {31'd0, vt[i].co});
      chk($sformatf("vec%0d ovf", i), {31'd0, ro}, {31'd0, vt[i].ov});
      chk($sformatf("vec%0d latency", i), lat, steps_of[vt[i].sel]);
      chk($sformatf("vec%0d busy cycles", i), bc, steps_of[vt[i].sel] + 1);
      chk($sformatf("vec%0d protocol", i), {31'd0, perr}, 32'd0);
    end

    // start held high with operands changing every cycle
    begin
      logic [7:0] ap, bp, al, bl;
      logic       cp, cl, pb;
      int         ndone, last_e;
      ndone = 0; last_e = -1; pb = 1'b0;
      al = '0; bl = '0; cl = 1'b0;
      @(negedge clk);
      ap = 8'h3A; bp = 8'hC9; cp = 1'b1;
      a_d = ap; b_d = bp; cin_d = cp; start_v[0] = 1'b1;
      for (int e = 1; e <= 36; e++) begin
        @(posedge clk); #1;
        if (busy_v[0] && !pb) begin al = ap; bl = bp; cl = cp; end
        pb = busy_v[0];
        if (done_v[0]) begin
          m = model(8, al, bl, cl);
          chk($sformatf("held-start result %0d", ndone), {22'd0, ovf_v[0], cout_v[0], sum_v[0]},
              {22'd0, m});
          if (last_e >= 0) chk($sformatf("held-start spacing %0d", ndone), e - last_e, 10);
          last_e = e;
          ndone++;
        end
        ap = 8'($urandom); bp = 8'($urandom); cp = 1'($urandom);
        a_d = ap; b_d = bp; cin_d = cp;
      end
      start_v[0] = 1'b0;
      chk("held-start result count", ndone, 3);
      repeat (12) @(posedge clk);
    end

    // reset in the middle of an operation
    run_op(0, 8'h7F, 8'h01, 1'b0, rs, rc, ro, lat, bc, perr);
    chk("pre-reset sum", {24'd0, rs}, 32'h80);
    @(negedge clk);
    a_d = 8'h55; b_d = 8'hAA; cin_d = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {27'd0, busy_v}, 32'd0);
    chk("abort done", {27'd0, done_v}, 32'd0);
    chk("abort sum0", {24'd0, sum_v[0]}, 32'd0);
    chk("abort cout/ovf", {22'd0, cout_v, ovf_v}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int e = 0; e < 12; e++) begin
        @(posedge clk); #1;
        if (done_v[0] || busy_v[0]) seen++;
      end
      chk("no done after abort", seen, 0);
    end
    run_op(0, 8'h01, 8'h02, 1'b1, rs, rc, ro, lat, bc, perr);
    chk("post-reset sum", {24'd0, rs}, 32'h04);
    chk("post-reset latency", lat, 8);

    // exhaustive 4-bit sweep
    for (int sel = 2; sel <= 4; sel++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          for (int c = 0; c < 2; c++) begin
            run_op(sel, 8'(x), 8'(y), 1'(c), rs, rc, ro, lat, bc, perr);
            m = model(width_of[sel], 8'(x), 8'(y), 1'(c));
            chk($sformatf("w4 sel%0d %0h+%0h+%0d", sel, x, y, c),
                {22'd0, ro, rc, rs}, {22'd0, m});
            chk($sformatf("w4 sel%0d latency %0h+%0h+%0d", sel, x, y, c), lat, steps_of[sel]);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 Parameter: DIGIT, default 1, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT; STEPS = WIDTH/DIGIT.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-009 Port: busy  output  1  high while in RUN or DONE.
REQ-010 Port: done  output  1  single-cycle completion pulse; high only in DONE.
REQ-011 Port: sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
REQ-012 Port: cout  output  1  registered unsigned carry-out of the MSB.
REQ-013 Port: ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: when start=1 on a rising edge, latch a, b and cin into internal shift registers, clear the step counter, and move to RUN; when start=0, remain in IDLE.
REQ-016 RUN: each edge adds the DIGIT LSBs of both operand registers plus the carry register, stores the DIGIT-bit result digit into the result shift register (filled LSB-first), updates the carry register, shifts both operands right by DIGIT, and increments the counter.
REQ-017 RUN: the edge that processes digit STEPS-1 SHALL move the FSM to DONE and load sum, cout and ovf from the completed result in the same edge.
REQ-018 Latency: with the accepting edge counted as edge 0, done SHALL be high in the cycle that follows edge STEPS (WIDTH=8, DIGIT=1: 8 edges; WIDTH=8, DIGIT=4: 2 edges).
REQ-019 DONE: unconditional transition to IDLE on the next edge; done is high for exactly one cycle.
REQ-020 sum, cout and ovf SHALL change only on the edge that enters DONE, and SHALL hold through IDLE until the next result is loaded; intermediate RUN values SHALL never appear on these outputs.
REQ-021 start in RUN or DONE SHALL be ignored, with no effect on the operation in progress and no queuing; minimum spacing between accepted starts is STEPS+2 edges.
REQ-022 a, b and cin changing after the accepting edge SHALL NOT affect the result.
REQ-023 ovf for the last digit SHALL use the carry into bit WIDTH-1, computed inside that digit when DIGIT > 1.
REQ-024 The counter SHALL be ceil(log2(STEPS+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state to IDLE and clear busy, done, sum, cout, ovf, the carry register, the counter and all shift registers to 0.
REQ-026 A reset asserted in RUN or DONE SHALL abort the operation with no done pulse; after rst_n returns to 1, the first start is accepted normally.

Verification
REQ-027 WIDTH=8, DIGIT=1; a=0x7F, b=0x01, cin=0, start pulsed -> busy high for 9 cycles, done pulse 8 edges after acceptance, sum=0x80, cout=0, ovf=1.
REQ-028 WIDTH=8, DIGIT=1; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-029 WIDTH=8, DIGIT=1; start held high continuously and operands changed mid-RUN -> one result per 10 edges, each matching the operands latched at its accepting edge.
REQ-030 WIDTH=8, DIGIT=1; rst_n pulsed low at step 4 of a=0x55, b=0xAA -> all outputs 0 immediately, no done pulse; next start with a=0x01, b=0x02, cin=1 -> sum=0x04.
REQ-031 WIDTH=8, DIGIT=4; a=0x80, b=0x80, cin=0 -> done 2 edges after acceptance, sum=0x00, cout=1, ovf=1.
REQ-032 WIDTH=4 with DIGIT=1, 2 and 4; exhaustive sweep of a, b and cin (512 cases) -> sum, cout and ovf match a reference model; latency is STEPS edges in every case.
